cronometer_prog: RTL and testbench
==================================

Name: cronometer_prog

Overview:
Programmable timeout timer for the lab system, replacing the fixed-limit cronometer. The terminal count is loaded at run time, a clock prescaler slows the counting rate, and the block supports one-shot and periodic modes plus pause and manual clear. It sits beside the control FSMs and supplies a sticky timeout level and a one-cycle expiry tick.

Parameters:
WIDTH, 30, width of the count and limit.
PRESCALE, 1, clock cycles per count increment; must be >= 1, and 1 means the count advances every cycle.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; loads limit and periodic, starts counting
clear  in  1  manual clear; returns the block to idle
pause  in  1  level; freezes the count and prescaler while high in RUN
periodic  in  1  mode select, sampled with start: 0 = one-shot, 1 = periodic
limit  in  WIDTH  terminal count, sampled with start
count  out  WIDTH  current count
running  out  1  high in RUN
timeout  out  1  sticky level, high in DONE
tick  out  1  one-cycle pulse on each expiry

Behaviour:
- Reset is synchronous and active-high. On rst: state IDLE; count, prescaler, latched limit and latched mode all 0; running, timeout and tick all 0.
- Priority, highest first: rst > clear > start > pause > advance.
- States are IDLE, RUN and DONE.
- clear, in any state: next state IDLE, count 0, prescaler 0, timeout 0, tick 0.
- start, in IDLE or DONE:
  - Latch limit into limit_q and periodic into mode_q.
  - count 0, prescaler 0, timeout 0, next state RUN.
  - If limit == 0: go directly to DONE. tick = 1 and timeout = 1 on the next edge, count stays 0. This applies in both modes, so periodic mode cannot run away.
- start while in RUN is ignored. A restart requires clear first.
- Advance enable: state == RUN and pause == 0, and the prescaler is at PRESCALE-1. The prescaler then wraps to 0. Otherwise the prescaler increments while in RUN with pause low.
- Expiry: an advance while count == limit_q-1.
  - One-shot: count <- limit_q, state DONE, tick = 1 for one cycle, timeout = 1 and held until clear, start or rst.
  - Periodic: count <- 0, tick = 1 for one cycle, stays in RUN, timeout stays 0.
- Normal advance (not expiry): count <- count+1.
- The count never exceeds limit_q, so no wrap-around or overflow is possible. The prescaler counter width is max(1, $clog2(PRESCALE)).
- Latency:
  - One-shot: timeout rises exactly limit*PRESCALE clock edges after the edge that accepted start, excluding edges where pause was high.
  - Periodic: tick pulses every limit*PRESCALE unpaused cycles.
- pause in IDLE or DONE has no effect. Pause never loses or repeats a prescaler step.
- All outputs are registered. tick is never high for two consecutive cycles unless limit*PRESCALE == 1.

Decomposition:
- Package cronometer_pkg holds:
  - typedef enum logic [1:0] timer_state_e {IDLE, RUN, DONE}.
  - LIMIT_PROD = 750_000_000 (15 s at 50 MHz).
  - LIMIT_TEST = 20.
- One sub-module, tick_prescaler, parameterised by PRESCALE. Inputs: clk, rst, clr, en. Output: stb, which pulses every PRESCALE enabled cycles. It is cleared by clear and by start.

Test Plan:
1. WIDTH=8, PRESCALE=1, limit=5, periodic=0, start at edge 0 -> count 1,2,3,4,5; timeout=1 and tick=1 after edge 5; tick=0 after edge 6; count holds 5.
2. PRESCALE=2, limit=3, periodic=1 -> count sequence 0,0,1,1,2,2,0,... with tick high for one cycle every 6 cycles; timeout stays 0.
3. limit=10, PRESCALE=1, pause high for 4 cycles at count 3 -> count frozen at 3 during pause, running=1; timeout after edge 14.
4. In RUN at count 4, clear and start asserted together -> next edge: IDLE, count 0, running 0, start ignored.
5. limit=0, start -> next edge: DONE, tick=1, timeout=1, count 0, in both modes.
6. rst at count 4 mid-run with start also high -> all outputs 0, state IDLE; the following start with limit=2 gives timeout after 2 edges.

Source files
------------

// File: rtl/cronometer_pkg.sv
// Shared types and constants for the programmable timeout timer.
package cronometer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    // 15 s at 50 MHz for the lab system, and a short limit for simulation.
    localparam int unsigned LIMIT_PROD = 750_000_000;
    localparam int unsigned LIMIT_TEST = 20;

endpackage : cronometer_pkg

// File: rtl/cronometer_prog_tick_prescaler.sv
// Divides enabled cycles by PRESCALE; stb marks the last cycle of each group.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic stb
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign stb = en && (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = stb ? '0 : cnt_q + PW'(1);
        end
    end

    // NOTE: reset is synchronous here, so it sits inside the clocked block only.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule : tick_prescaler

// File: rtl/cronometer_prog.sv
// Programmable timeout timer: loadable limit, prescaled counting, one-shot or
// periodic mode, pause and clear. All outputs come straight from flops.
module cronometer_prog
    import cronometer_pkg::*;
#(
    parameter int WIDTH    = 30,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             timeout,
    output logic             tick
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;
    logic             tick_q, tick_d;

    logic start_ok;
    logic pre_clr;
    logic pre_en;
    logic advance;

    // start is only honoured outside RUN; clear overrides it.
    assign start_ok = start && !clear && (state_q != RUN);
    assign pre_clr  = clear || start_ok;
    assign pre_en   = (state_q == RUN) && !pause && !clear;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk(clk),
        .rst(rst),
        .clr(pre_clr),
        .en (pre_en),
        .stb(advance)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        tick_d    = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            count_d   = '0;
            timeout_d = 1'b0;
        end else if (start_ok) begin
            limit_d   = limit;
            mode_d    = periodic;
            count_d   = '0;
            timeout_d = 1'b0;
            if (limit == '0) begin
                // A zero limit expires at once in either mode, so periodic cannot spin.
                state_d   = DONE;
                tick_d    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (advance) begin
            if (count_q == limit_q - WIDTH'(1)) begin
                tick_d = 1'b1;
                if (mode_q) begin
                    count_d = '0;
                end else begin
                    count_d   = limit_q;
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end

        running_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            tick_q    <= tick_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign timeout = timeout_q;
    assign tick    = tick_q;

endmodule : cronometer_prog

// File: tb/tb_cronometer_prog.sv
// Directed bench for cronometer_prog: one instance with PRESCALE=1, one with
// PRESCALE=2, expectations queued per edge and compared just after it.
module tb_cronometer_prog;

    logic       clk = 1'b0;
    logic       rst, start, clear, pause, periodic;
    logic [7:0] limit;

    logic [7:0] count_a, count_b;
    logic       running_a, running_b, timeout_a, timeout_b, tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [7:0] cnt;
        logic       run;
        logic       tmo;
        logic       tck;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cronometer_prog #(.WIDTH(8), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .pause(pause),
        .periodic(periodic), .limit(limit), .count(count_a),
        .running(running_a), .timeout(timeout_a), .tick(tick_a)
    );

    cronometer_prog #(.WIDTH(8), .PRESCALE(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .pause(pause),
        .periodic(periodic), .limit(limit), .count(count_b),
        .running(running_b), .timeout(timeout_b), .tick(tick_b)
    );

    task automatic expect_out(input string tag, input bit sel, input logic [7:0] c,
                              input logic r, input logic t, input logic k);
        exp_t e;
        e.tag = tag; e.sel = sel; e.cnt = c; e.run = r; e.tmo = t; e.tck = k;
        sb.push_back(e);
    endtask

    task automatic check_one(input string tag, input string fld,
                             input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    // Advance one edge, then compare every queued expectation.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                check_one(e.tag, "count",   count_b,          e.cnt);
                check_one(e.tag, "running", {7'd0, running_b}, {7'd0, e.run});
                check_one(e.tag, "timeout", {7'd0, timeout_b}, {7'd0, e.tmo});
                check_one(e.tag, "tick",    {7'd0, tick_b},    {7'd0, e.tck});
            end else begin
                check_one(e.tag, "count",   count_a,          e.cnt);
                check_one(e.tag, "running", {7'd0, running_a}, {7'd0, e.run});
                check_one(e.tag, "timeout", {7'd0, timeout_a}, {7'd0, e.tmo});
                check_one(e.tag, "tick",    {7'd0, tick_a},    {7'd0, e.tck});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; pause = 1'b0; periodic = 1'b0; limit = '0;

        // Reset state of both instances.
        expect_out("reset_a", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_out("reset_b", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // 1: one-shot, limit 5, prescale 1.
        limit = 8'd5; periodic = 1'b0; start = 1'b1;
        expect_out("t1_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_out($sformatf("t1_cnt%0d", i), 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        expect_out("t1_expire", 1'b0, 8'd5, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("t1_hold", 1'b0, 8'd5, 1'b0, 1'b1, 1'b0);
        step();

        // 2: periodic, limit 3, prescale 2; a start mid-run must be ignored.
        clear = 1'b1;
        expect_out("t2_clear", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        clear = 1'b0; limit = 8'd3; periodic = 1'b1; start = 1'b1;
        expect_out("t2_start", 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3) begin
                start = 1'b1; limit = 8'd1; periodic = 1'b0;
            end else begin
                start = 1'b0;
            end
            expect_out($sformatf("t2_e%0d", i), 1'b1, 8'((i / 2) % 3), 1'b1, 1'b0,
                       logic'(i % 6 == 0));
            step();
        end
        start = 1'b0;

        // 3: limit 10 with pause for 4 edges at count 3.
        clear = 1'b1;
        step();
        clear = 1'b0; limit = 8'd10; periodic = 1'b0; start = 1'b1;
        expect_out("t3_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            expect_out($sformatf("t3_cnt%0d", i), 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("t3_pause%0d", i), 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
            step();
        end
        pause = 1'b0;
        for (int i = 4; i <= 9; i++) begin
            expect_out($sformatf("t3_cnt%0d", i), 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        expect_out("t3_expire", 1'b0, 8'd10, 1'b0, 1'b1, 1'b1);
        step();

        // 4: clear and start together at count 4.
        clear = 1'b1;
        step();
        clear = 1'b0; limit = 8'd10; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_out($sformatf("t4_cnt%0d", i), 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        clear = 1'b1; start = 1'b1;
        expect_out("t4_clrstart", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        clear = 1'b0; start = 1'b0;
        expect_out("t4_idle", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();

        // 5: limit 0 in one-shot, then periodic (restart from DONE).
        limit = 8'd0; periodic = 1'b0; start = 1'b1;
        expect_out("t5_os_a", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        start = 1'b0;
        expect_out("t5_os_hold", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        periodic = 1'b1; start = 1'b1;
        expect_out("t5_per_a", 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        expect_out("t5_per_b", 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        start = 1'b0;
        expect_out("t5_per_hold_a", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        expect_out("t5_per_hold_b", 1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        step();

        // 6: reset at count 4 with start high, then a fresh limit-2 run.
        clear = 1'b1;
        step();
        clear = 1'b0; limit = 8'd10; periodic = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_out($sformatf("t6_cnt%0d", i), 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        rst = 1'b1; start = 1'b1;
        expect_out("t6_rst_a", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_out("t6_rst_b", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0; limit = 8'd2; start = 1'b1;
        expect_out("t6_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        expect_out("t6_cnt1", 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("t6_expire", 1'b0, 8'd2, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("t6_hold", 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cronometer_prog
